// File: rtl/osc_clk_ctrl.sv
// osc_clk_ctrl: settle gate plus round-robin shared clock-enable divider.
// Ports: CLK/RSTN, REQ[NREQ] in, DIV[DIV_W] in, GNT[NREQ]/TICK/STABLE/BUSY out.
module osc_clk_ctrl #(
  parameter int SETTLE_CYC = 1024,
  parameter int NREQ       = 4,
  parameter int DIV_W      = 8,
  parameter int QUANTUM    = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [NREQ-1:0]  REQ,
  input  logic [DIV_W-1:0] DIV,
  output logic [NREQ-1:0]  GNT,
  output logic             TICK,
  output logic             STABLE,
  output logic             BUSY
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TW = $clog2(QUANTUM + 1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] Q_LAST = TW'(QUANTUM);
  localparam logic [PW-1:0] P_LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {SETTLE, IDLE, RUN} state_t;

  state_t            state;
  state_t            state_d;
  logic [SW-1:0]     scnt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic [PW-1:0]     win_c;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  dcnt;
  logic [DIV_W-1:0]  dcnt_inc;
  logic [TW-1:0]     tcnt;
  logic              any_req;
  logic              settled;
  logic              tick_due;
  logic              rel;
  logic [NREQ-1:0]   gnt_d;
  logic              tick_d;
  logic              busy_d;

  function automatic logic [PW-1:0] rot(
    input logic [PW-1:0] p,
    input int            i
  );
    int j;
    j = int'(p) + i;
    if (j >= NREQ) j = j - NREQ;
    return PW'(j);
  endfunction

  assign any_req  = |REQ;
  assign settled  = (scnt == S_LAST);
  assign dcnt_inc = dcnt + 1'b1;
  assign tick_due = (dcnt_inc == div_q);
  // TICK high with tcnt==QUANTUM means the last tick of the grant is out now
  assign rel      = ~REQ[win] | (TICK & (tcnt == Q_LAST));

  // scan from farthest offset down so the nearest set bit at/after ptr wins
  always_comb begin
    win_c = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[rot(ptr, i)]) win_c = rot(ptr, i);
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      SETTLE:  if (settled) state_d = IDLE;
      IDLE:    if (any_req) state_d = RUN;
      RUN:     if (rel) state_d = IDLE;
      default: state_d = SETTLE;
    endcase
  end

  always_comb begin
    gnt_d  = '0;
    tick_d = 1'b0;
    busy_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          gnt_d  = NREQ'(1) << win_c;
          busy_d = 1'b1;
        end
      end
      RUN: begin
        if (!rel) begin
          gnt_d  = GNT;
          busy_d = 1'b1;
          tick_d = tick_due;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= SETTLE;
      scnt   <= '0;
      ptr    <= '0;
      win    <= '0;
      div_q  <= '0;
      dcnt   <= '0;
      tcnt   <= '0;
      GNT    <= '0;
      TICK   <= 1'b0;
      BUSY   <= 1'b0;
      STABLE <= 1'b0;
    end else begin
      state  <= state_d;
      GNT    <= gnt_d;
      TICK   <= tick_d;
      BUSY   <= busy_d;
      STABLE <= (state_d != SETTLE);
      unique case (state)
        SETTLE: begin
          if (!settled) scnt <= scnt + 1'b1;
        end
        IDLE: begin
          if (any_req) begin
            win   <= win_c;
            div_q <= (DIV == '0) ? DIV_W'(1) : DIV;
            dcnt  <= '0;
            tcnt  <= '0;
          end
        end
        RUN: begin
          if (rel) begin
            ptr <= (win == P_LAST) ? '0 : win + 1'b1;
          end else if (tick_due) begin
            dcnt <= '0;
            tcnt <= tcnt + 1'b1;
          end else begin
            dcnt <= dcnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_clk_ctrl.sv
// tb_osc_clk_ctrl: directed vectors and corner sequences for osc_clk_ctrl.
// SETTLE_CYC=16, NREQ=4, DIV_W=8, QUANTUM=3.
module tb_osc_clk_ctrl;

  localparam int SC = 16;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int Q  = 3;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic [NR-1:0] REQ = '0;
  logic [DW-1:0] DIV = '0;
  logic [NR-1:0] GNT;
  logic          TICK;
  logic          STABLE;
  logic          BUSY;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic [7:0] div;
    logic [3:0] gnt;
    logic       tick;
    logic       busy;
  } vec_t;

  vec_t tv[24];

  always #5 CLK = ~CLK;

  osc_clk_ctrl #(
    .SETTLE_CYC(SC),
    .NREQ(NR),
    .DIV_W(DW),
    .QUANTUM(Q)
  ) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .REQ(REQ),
    .DIV(DIV),
    .GNT(GNT),
    .TICK(TICK),
    .STABLE(STABLE),
    .BUSY(BUSY)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] g,
                         input logic t, input logic b, input logic s);
    chk(nm, {GNT, TICK, BUSY, STABLE}, {g, t, b, s});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    for (int k = 1; k <= SC; k++) begin
      step();
      chk("settle_stable", STABLE, (k == SC));
      chk("settle_gnt", GNT, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] eg;
    int ord[5];

    tv[0]  = '{4'b0001, 8'd4, 4'b0001, 1'b0, 1'b1};
    tv[1]  = '{4'b0001, 8'd4, 4'b0001, 1'b0, 1'b1};
    tv[2]  = '{4'b0001, 8'd4, 4'b0001, 1'b0, 1'b1};
    tv[3]  = '{4'b0001, 8'd4, 4'b0001, 1'b1, 1'b1};
    tv[4]  = '{4'b0001, 8'd4, 4'b0001, 1'b0, 1'b1};
    tv[5]  = '{4'b0001, 8'd4, 4'b0001, 1'b0, 1'b1};
    tv[6]  = '{4'b0001, 8'd9, 4'b0001, 1'b0, 1'b1};
    tv[7]  = '{4'b0001, 8'd9, 4'b0001, 1'b1, 1'b1};
    tv[8]  = '{4'b0001, 8'd9, 4'b0001, 1'b0, 1'b1};
    tv[9]  = '{4'b0001, 8'd9, 4'b0001, 1'b0, 1'b1};
    tv[10] = '{4'b0001, 8'd9, 4'b0001, 1'b0, 1'b1};
    tv[11] = '{4'b0001, 8'd9, 4'b0001, 1'b1, 1'b1};
    tv[12] = '{4'b0001, 8'd9, 4'b0000, 1'b0, 1'b0};
    tv[13] = '{4'b0001, 8'd5, 4'b0001, 1'b0, 1'b1};
    tv[14] = '{4'b0001, 8'd5, 4'b0001, 1'b0, 1'b1};
    tv[15] = '{4'b0001, 8'd5, 4'b0001, 1'b0, 1'b1};
    tv[16] = '{4'b0000, 8'd5, 4'b0000, 1'b0, 1'b0};
    tv[17] = '{4'b0000, 8'd0, 4'b0000, 1'b0, 1'b0};
    tv[18] = '{4'b0001, 8'd0, 4'b0001, 1'b0, 1'b1};
    tv[19] = '{4'b0001, 8'd9, 4'b0001, 1'b1, 1'b1};
    tv[20] = '{4'b0001, 8'd9, 4'b0001, 1'b1, 1'b1};
    tv[21] = '{4'b0001, 8'd9, 4'b0001, 1'b1, 1'b1};
    tv[22] = '{4'b0001, 8'd9, 4'b0000, 1'b0, 1'b0};
    tv[23] = '{4'b0000, 8'd9, 4'b0000, 1'b0, 1'b0};

    ord = '{0, 1, 3, 0, 1};

    // reset and settle, request already pending
    RSTN = 1'b0;
    REQ  = 4'b0001;
    DIV  = 8'd4;
    repeat (3) step();
    chk_out("reset_state", 4'b0000, 1'b0, 1'b0, 1'b0);
    RSTN = 1'b1;
    settle();
    step();
    chk_out("first_grant", 4'b0001, 1'b0, 1'b1, 1'b1);

    // quantum, regrant, DIV change ignored, REQ drop, DIV=0
    for (int i = 0; i < 24; i++) begin
      REQ = tv[i].req;
      DIV = tv[i].div;
      step();
      chk_out($sformatf("vec%0d", i), tv[i].gnt, tv[i].tick,
              tv[i].busy, 1'b1);
    end

    // async reset in the middle of a grant
    REQ = 4'b0100;
    DIV = 8'd5;
    step();
    chk_out("grant_bit2", 4'b0100, 1'b0, 1'b1, 1'b1);
    step();
    step();
    #3;
    RSTN = 1'b0;
    #1;
    chk_out("async_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    REQ = 4'b1011;
    DIV = 8'd1;
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    settle();
    step();

    // round robin from ptr=0 with three requesters
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << ord[k];
      chk("rr_gnt", GNT, eg);
      chk("rr_busy", BUSY, 1);
      for (int t = 0; t < Q; t++) begin
        step();
        chk("rr_tick", TICK, 1);
        chk("rr_hold", GNT, eg);
        chk("rr_onehot", $onehot0(GNT), 1);
      end
      step();
      chk_out("rr_release", 4'b0000, 1'b0, 1'b0, 1'b1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
